// File: rtl/gnr_node_lut.sv
// gnr_node_lut: multi-channel Boolean-network node with a shared runtime truth table, per-channel update divider and optional stability flag (GNR_NODE_STABLE_EN)
module gnr_node_lut #(
    parameter int K = 4,
    parameter int C = 2,
    parameter int DIV_W = 4,
    parameter logic [(1<<K)-1:0] LUT_INIT = 16'hC080,
    parameter int STB_W = 4,
    parameter int STABLE_N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reset_nos,
    input  logic [C-1:0]         init_state,
    input  logic [C-1:0]         start,
    input  logic [C*K-1:0]       regs,
    input  logic [C*DIV_W-1:0]   div,
    input  logic                 lut_we,
    input  logic [(1<<K)-1:0]    lut_wdata,
    output logic [C-1:0]         s,
    output logic [C-1:0]         upd,
    output logic [C-1:0]         stable
);
    logic [(1<<K)-1:0] lut_q;

    // shared truth table; same-cycle evaluations still see the old contents
    always_ff @(posedge clk) begin
        if (rst) lut_q <= LUT_INIT;
        else if (lut_we) lut_q <= lut_wdata;
    end

    for (genvar c = 0; c < C; c++) begin : g_ch
        logic [DIV_W-1:0] ph;
        logic             s_q;
        logic             upd_q;
        logic             nv;
        logic             ev;
        assign nv = lut_q[regs[c*K +: K]];
        assign ev = start[c] && (ph == '0);
        assign s[c] = s_q;
        assign upd[c] = upd_q;

        // state, phase and update pulse; network re-init beats the strobe
        always_ff @(posedge clk) begin
            if (rst) begin
                s_q   <= 1'b0;
                ph    <= '0;
                upd_q <= 1'b0;
            end else if (reset_nos) begin
                s_q   <= init_state[c];
                ph    <= '0;
                upd_q <= 1'b0;
            end else begin
                upd_q <= ev;
                if (ev) begin
                    s_q <= nv;
                    ph  <= div[c*DIV_W +: DIV_W];
                end else if (start[c]) begin
                    ph  <= ph - 1'b1;
                end
            end
        end

`ifdef GNR_NODE_STABLE_EN
        logic [STB_W-1:0] cnt;
        logic [STB_W-1:0] cnt_n;
        logic             st_q;
        assign cnt_n = (nv != s_q) ? '0 : (&cnt) ? cnt : cnt + 1'b1;
        assign stable[c] = st_q;

        // run length of unchanged evaluations, flag refreshed alongside upd
        always_ff @(posedge clk) begin
            if (rst || reset_nos) begin
                cnt  <= '0;
                st_q <= 1'b0;
            end else if (ev) begin
                cnt  <= cnt_n;
                st_q <= (cnt_n >= STB_W'(STABLE_N));
            end
        end
`else
        assign stable[c] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_gnr_node_lut.sv
// tb_gnr_node_lut: scoreboard bench for gnr_node_lut (K=4, C=2, LUT_INIT=16'hC080)
module tb_gnr_node_lut;
`ifdef GNR_NODE_STABLE_EN
    localparam bit STB_EN = 1'b1;
`else
    localparam bit STB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, reset_nos, lut_we;
    logic [1:0]  init_state, start, s, upd, stable;
    logic [7:0]  regs, div;
    logic [15:0] lut_wdata;

    typedef struct {
        string      tag;
        logic [1:0] s;
        logic [1:0] upd;
        logic [1:0] st;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_lut;
    logic [1:0]  m_s, m_upd, m_st;
    int          m_ph[2];
    int          m_cnt[2];

    always #5 clk = ~clk;

    gnr_node_lut dut (
        .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
        .start(start), .regs(regs), .div(div), .lut_we(lut_we),
        .lut_wdata(lut_wdata), .s(s), .upd(upd), .stable(stable)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // predict the post-edge outputs from the current inputs, clock once, compare
    task automatic step(input string tag);
        exp_t e;
        logic nv;
        if (rst) begin
            m_lut = 16'hC080;
            m_s = 2'b00; m_upd = 2'b00; m_st = 2'b00;
            m_ph = '{0, 0}; m_cnt = '{0, 0};
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (reset_nos) begin
                    m_s[c] = init_state[c]; m_ph[c] = 0; m_upd[c] = 1'b0;
                    m_cnt[c] = 0; m_st[c] = 1'b0;
                end else if (start[c] && m_ph[c] == 0) begin
                    nv = m_lut[regs[c*4 +: 4]];
                    m_cnt[c] = (nv != m_s[c]) ? 0 : (m_cnt[c] == 15 ? 15 : m_cnt[c] + 1);
                    m_st[c] = (m_cnt[c] >= 8);
                    m_s[c] = nv;
                    m_ph[c] = int'(div[c*4 +: 4]);
                    m_upd[c] = 1'b1;
                end else begin
                    if (start[c]) m_ph[c]--;
                    m_upd[c] = 1'b0;
                end
            end
            if (lut_we) m_lut = lut_wdata;
        end
        e.tag = tag; e.s = m_s; e.upd = m_upd; e.st = STB_EN ? m_st : 2'b00;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".s"}, s, e.s);
        chk({e.tag, ".upd"}, upd, e.upd);
        chk({e.tag, ".stable"}, stable, e.st);
    endtask

    initial begin
        rst = 1'b1; reset_nos = 1'b0; init_state = 2'b00; start = 2'b00;
        regs = 8'h00; div = 8'h00; lut_we = 1'b0; lut_wdata = 16'h0000;
        step("reset");
        chk("reset_state", s | upd | stable, 2'b00);

        // divider pattern: ch0 div=0, ch1 div=1
        rst = 1'b0; reset_nos = 1'b1; init_state = 2'b11; div = 8'h10; regs = 8'h66;
        step("nos_init");
        chk("nos_init_s", s, 2'b11);
        reset_nos = 1'b0; start = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step("divider");
            chk("div_s", s, 2'b00);
            chk("div_upd", upd, (i % 2 == 0) ? 2'b11 : 2'b01);
        end
        start = 2'b00;
        step("idle");

        // truth table sweep on ch0
        div = 8'h00; regs[7:4] = 4'h0; start = 2'b01;
        for (int i = 0; i < 16; i++) begin
            regs[3:0] = 4'(i);
            step("sweep");
            chk("sweep_s0", {1'b0, s[0]}, {1'b0, (i == 7 || i == 14 || i == 15)});
        end

        // table write collides with a strobe: old table used
        regs = 8'h00; lut_we = 1'b1; lut_wdata = 16'hFFFF;
        step("lut_wr");
        chk("lut_wr_old", {1'b0, s[0]}, 2'b00);
        lut_we = 1'b0;
        step("lut_new");
        chk("lut_wr_new", {1'b0, s[0]}, 2'b01);

        // reset_nos beats start, held for two cycles
        reset_nos = 1'b1; start = 2'b11; init_state = 2'b01; div = 8'h11;
        step("nos_prio");
        chk("nos_prio_s", s, 2'b01);
        chk("nos_prio_upd", upd, 2'b00);
        init_state = 2'b10;
        step("nos_hold");
        chk("nos_hold_s", s, 2'b10);
        reset_nos = 1'b0; start = 2'b01;
        step("ph_zero");
        chk("ph_zero_upd", upd, 2'b01);

        // stability run under the all-ones table
        reset_nos = 1'b1; init_state = 2'b00; start = 2'b00; div = 8'h00;
        step("stb_init");
        reset_nos = 1'b0; regs = 8'h77; start = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            step("stb_run1");
            chk("stb_run1_flag", stable, (STB_EN && k >= 9) ? 2'b11 : 2'b00);
        end

        // reset mid-run: outputs clear and the table returns to LUT_INIT
        rst = 1'b1;
        step("rst_mid");
        chk("rst_mid_all", s | upd | stable, 2'b00);
        rst = 1'b0; reset_nos = 1'b1; start = 2'b00;
        step("post_rst_init");
        reset_nos = 1'b0; regs = 8'h66; start = 2'b01;
        step("post_rst_lut");
        chk("post_rst_lut_s0", {1'b0, s[0]}, 2'b00);

        // stability rise then drop under the reset table
        regs = 8'h77; start = 2'b11;
        for (int k = 1; k <= 9; k++) begin
            step("stb_run2");
            chk("stb_run2_flag", stable, (STB_EN && k == 9) ? 2'b11 : 2'b00);
        end
        regs = 8'h00;
        step("stb_drop");
        chk("stb_drop_s", s, 2'b00);
        chk("stb_drop_flag", stable, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
